// File: rtl/lsu_mem_responder.sv
// Memory responder for the LSU data port. It serves one read or write at a time against an internal word array.
// Latency: resp_valid is first seen by the LSU at the LATENCY-th rising edge after the accept edge.
// Backpressure: req_ready is low from accept until the response handshake. The response is held until resp_ready is high.
module lsu_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;

  // Request fields captured at accept
  logic              lat_wen;
  logic              lat_inr;
  logic [IDX_W-1:0]  lat_idx;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_wmask;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       req_off;
  logic              req_inr;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              enter_resp;

  // Fields of the transaction that is entering RESP on this edge
  logic              cur_wen;
  logic              cur_inr;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wmask;
  logic              mem_we;

  // Upper mask lanes carry no meaning for a 32-bit word
  logic              unused_bits;
  assign unused_bits = ^req_wmask[7:4];

  // Addresses below the base wrap to a large offset and decode as out of range
  assign req_off    = req_addr - BASE_ADDR;
  assign req_inr    = (req_off < SPAN);
  assign req_idx    = req_off[IDX_W+1:2];
  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // With LATENCY==1 the accept edge is also the RESP entry edge, so use the live request in IDLE
  always_comb begin
    if (state == IDLE) begin
      cur_wen   = req_wen;
      cur_inr   = req_inr;
      cur_idx   = req_idx;
      cur_wdata = req_wdata;
      cur_wmask = req_wmask[3:0];
    end else begin
      cur_wen   = lat_wen;
      cur_inr   = lat_inr;
      cur_idx   = lat_idx;
      cur_wdata = lat_wdata;
      cur_wmask = lat_wmask;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come from state only, with no input-to-output path
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  // Capture the request at accept and count down the wait cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_wen   <= 1'b0;
      lat_inr   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_wmask <= 4'd0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_wen   <= req_wen;
      lat_inr   <= req_inr;
      lat_idx   <= req_idx;
      lat_wdata <= req_wdata;
      lat_wmask <= req_wmask[3:0];
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response payload is loaded on RESP entry and cleared at the response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= !cur_inr;
      resp_rdata <= (cur_inr && !cur_wen) ? mem[cur_idx] : 32'd0;
    end else if ((state == RESP) && resp_ready) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // A write commits only on the RESP entry edge. A reset before that edge drops it.
  assign mem_we = enter_resp && !rst && cur_wen && cur_inr;

  // Byte-lane write into the array. The array contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wmask[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed and random bench for lsu_mem_responder, with a scoreboard of expected responses.
// Latency: measures the number of edges from accept to when resp_valid is seen, and compares it with LAT.
// Backpressure: drives resp_ready stalls and checks that the response and req_ready hold during them.
module tb_lsu_mem_responder #(
  parameter int LAT = 2
);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] mdl [int];

  lsu_mem_responder #(
    .BASE_ADDR(32'h8000_0000),
    .DEPTH    (1024),
    .LATENCY  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: push the expected response and update the shadow array
  task automatic model(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] wmask);
    logic [31:0] off;
    int          idx;
    logic [31:0] w;
    exp_t        e;
    off = addr - 32'h8000_0000;
    idx = int'(off >> 2);
    e.rdata = 32'd0;
    e.err   = 1'b0;
    if (off >= 32'd4096) begin
      e.err = 1'b1;
    end else if (wen) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
      end
      mdl[idx] = w;
    end else begin
      e.rdata = mdl.exists(idx) ? mdl[idx] : 32'd0;
    end
    sb.push_back(e);
  endtask

  // One full transaction. The task is entered and left at #1 after a rising edge.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] wmask, input int stall);
    int          t;
    int          n;
    exp_t        e;
    logic [31:0] held;
    model(wen, addr, wdata, wmask);
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    resp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
    e = sb.pop_front();
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
    held = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, held);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("post_hs_rdata", resp_rdata, 32'd0);
    check("post_hs_err", {31'd0, resp_err}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wmask  = 8'd0;
    resp_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Full write, then read back with resp_ready held high
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0);
    txn(1'b0, 32'h8000_0010, 32'd0, 8'h00, 0);
    // Partial write to lane 1
    txn(1'b1, 32'h8000_0010, 32'h0000_AA00, 8'h02, 0);
    txn(1'b0, 32'h8000_0010, 32'd0, 8'h00, 0);
    // Response held off for 5 cycles
    txn(1'b0, 32'h8000_0010, 32'd0, 8'h00, 5);
    // An empty mask is acknowledged and leaves the word unchanged
    txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 1);
    txn(1'b0, 32'h8000_0010, 32'd0, 8'h00, 0);

    // Range edges: first and last words are valid, base+4096 and base-4 are errors
    txn(1'b1, 32'h8000_0000, 32'h1111_1111, 8'h0F, 0);
    txn(1'b1, 32'h8000_0FFC, 32'h2222_2222, 8'h0F, 0);
    txn(1'b1, 32'h8000_1000, 32'hBADB_AD00, 8'h0F, 0);
    txn(1'b1, 32'h7FFF_FFFC, 32'hBADB_AD01, 8'h0F, 0);
    txn(1'b0, 32'h8000_0000, 32'd0, 8'h00, 0);
    txn(1'b0, 32'h8000_0FFC, 32'd0, 8'h00, 2);
    txn(1'b0, 32'h8000_1000, 32'd0, 8'h00, 0);
    txn(1'b0, 32'h7FFF_FFFC, 32'd0, 8'h00, 1);

    // Reset in the middle of a write. The write commits only if it already reached RESP (LAT==1).
    txn(1'b1, 32'h8000_0020, 32'd0, 8'h0F, 0);
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 8'h0F;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_err", {31'd0, resp_err}, 32'd0);
    if (LAT == 1) mdl[8] = 32'h1234_5678;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
    txn(1'b0, 32'h8000_0020, 32'd0, 8'h00, 0);

    // Random traffic over a small window plus occasional out-of-range addresses
    for (int k = 0; k < 16; k++) begin
      txn(1'b1, 32'h8000_0100 + 32'(4 * k), $urandom, 8'h0F, 0);
    end
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 32'h8000_1000 + 32'(4 * $urandom_range(0, 15))
                                        : 32'h7FFF_FF00;
      end else begin
        a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15));
      end
      txn(1'($urandom_range(0, 1)), a, $urandom, 8'($urandom_range(0, 255)),
          $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
